// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a 1 KiB block RAM with a registered read port.
// Each request becomes one aligned word access; loads are extended, stores use an active-low byte mask.
module load_store_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           store_data,
  output logic [31:0]           load_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_data_in,
  input  logic [31:0]           ram_data_out,
  output logic [3:0]            ram_write_mask,
  output logic                  ram_write_enable
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

  state_t      state, state_d;
  logic        accept, legal;
  logic [1:0]  addr_lo;
  logic [2:0]  funct3_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] extracted, st_data;
  logic [3:0]  st_mask;

  assign accept = start && (state == IDLE || state == DONE);

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~address[0];
      3'b010:  legal = (address[1:0] == 2'b00);
      3'b100:  legal = ~is_store;
      3'b101:  legal = ~is_store & ~address[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: begin
        if (!start)      state_d = IDLE;
        else if (!legal) state_d = DONE;
        else if (is_store) state_d = WRITE;
        else             state_d = READ;
      end
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Store lane replication and mask, evaluated on the request inputs at acceptance
  always_comb begin
    st_data = store_data;
    st_mask = 4'b0000;
    case (funct3[1:0])
      2'b00: begin
        st_data = {4{store_data[7:0]}};
        st_mask = ~(4'b0001 << address[1:0]);
      end
      2'b01: begin
        st_data = {2{store_data[15:0]}};
        st_mask = address[1] ? 4'b0011 : 4'b1100;
      end
      default: begin
        st_data = store_data;
        st_mask = 4'b0000;
      end
    endcase
  end

  always_comb begin
    byte_sel  = ram_data_out[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? ram_data_out[31:16] : ram_data_out[15:0];
    extracted = ram_data_out;
    case (funct3_q)
      3'b000:  extracted = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  extracted = {24'b0, byte_sel};
      3'b001:  extracted = {{16{half_sel[15]}}, half_sel};
      3'b101:  extracted = {16'b0, half_sel};
      default: extracted = ram_data_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      load_data        <= 32'b0;
      ram_address      <= '0;
      ram_data_in      <= 32'b0;
      ram_write_mask   <= 4'b1111;
      ram_write_enable <= 1'b0;
      addr_lo          <= 2'b0;
      funct3_q         <= 3'b0;
    end else begin
      busy             <= (state_d == READ) || (state_d == CAPTURE) || (state_d == WRITE);
      done             <= (state_d == DONE);
      ram_write_enable <= (state_d == WRITE);
      ram_write_mask   <= (state_d == WRITE) ? st_mask : 4'b1111;
      if (accept) begin
        error    <= ~legal;
        addr_lo  <= address[1:0];
        funct3_q <= funct3;
        if (legal) ram_address <= {address[ADDR_WIDTH-1:2], 2'b00};
        if (legal && is_store) ram_data_in <= st_data;
      end
      if (state == CAPTURE) load_data <= extracted;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read byte-masked RAM model.
module tb_load_store_unit;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset, start, is_store;
  logic [2:0]    funct3;
  logic [AW-1:0] address;
  logic [31:0]   store_data, load_data, ram_data_in, ram_data_out;
  logic          busy, done, error, ram_write_enable;
  logic [AW-1:0] ram_address;
  logic [3:0]    ram_write_mask;

  int tests = 0, fails = 0;
  int wr_cnt = 0, done_cnt = 0;
  logic [31:0] mem [0:255];

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .address(address), .store_data(store_data), .load_data(load_data), .busy(busy),
    .done(done), .error(error), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .ram_write_mask(ram_write_mask),
    .ram_write_enable(ram_write_enable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write_enable) begin
      wr_cnt <= wr_cnt + 1;
      for (int b = 0; b < 4; b++)
        if (!ram_write_mask[b]) mem[ram_address[AW-1:2]][8*b +: 8] <= ram_data_in[8*b +: 8];
    end
    if (done) done_cnt <= done_cnt + 1;
    ram_data_out <= mem[ram_address[AW-1:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one accepting edge; returns #1 into the first cycle after acceptance
  task automatic issue(input logic st, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [31:0] d);
    is_store = st; funct3 = f3; address = a; store_data = d; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] mask, input logic [31:0] wdata);
    issue(1'b1, f3, a, d);
    chk({tag, " wen"}, {31'b0, ram_write_enable}, 32'd1);
    chk({tag, " mask"}, {28'b0, ram_write_mask}, {28'b0, mask});
    chk({tag, " wdata"}, ram_data_in, wdata);
    chk({tag, " addr"}, {22'b0, ram_address}, {22'b0, a[AW-1:2], 2'b00});
    step();
    chk({tag, " done"}, {30'b0, done, error}, 32'd2);
    chk({tag, " wen off"}, {27'b0, ram_write_enable, ram_write_mask}, 32'h0F);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [AW-1:0] a,
                         input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, " read"}, {30'b0, busy, ram_write_enable}, 32'd2);
    step();
    chk({tag, " no early done"}, {31'b0, done}, 32'd0);
    step();
    chk({tag, " done"}, {30'b0, done, error}, 32'd2);
    chk({tag, " data"}, load_data, exp);
  endtask

  task automatic do_error(input string tag, input logic st, input logic [2:0] f3,
                          input logic [AW-1:0] a, input logic [31:0] hold);
    int w0;
    w0 = wr_cnt;
    issue(st, f3, a, 32'h5555_5555);
    chk({tag, " done+err"}, {30'b0, done, error}, 32'd3);
    chk({tag, " no wen"}, {31'b0, ram_write_enable}, 32'd0);
    step();
    chk({tag, " no write"}, wr_cnt - w0, 32'd0);
    chk({tag, " load_data held"}, load_data, hold);
  endtask

  initial begin
    int d0, w0;
    reset = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b0; address = '0; store_data = '0;
    step(); step();
    chk("rst busy/done/err", {29'b0, busy, done, error}, 32'd0);
    chk("rst load_data", load_data, 32'd0);
    chk("rst ram_address", {22'b0, ram_address}, 32'd0);
    chk("rst ram_data_in", ram_data_in, 32'd0);
    chk("rst mask/wen", {27'b0, ram_write_enable, ram_write_mask}, 32'h0F);
    reset = 1'b1;
    d0 = done_cnt; w0 = wr_cnt;
    repeat (10) step();
    chk("idle no done", done_cnt - d0, 32'd0);
    chk("idle no write", wr_cnt - w0, 32'd0);

    do_store("SW", 3'b010, 10'h010, 32'hDEAD_BEEF, 4'b0000, 32'hDEAD_BEEF);
    do_load("LW", 3'b010, 10'h010, 32'hDEAD_BEEF);
    do_store("SB", 3'b000, 10'h013, 32'h0000_0080, 4'b0111, 32'h8080_8080);
    do_load("LB", 3'b000, 10'h013, 32'hFFFF_FF80);
    do_load("LBU", 3'b100, 10'h013, 32'h0000_0080);
    do_load("LW after SB", 3'b010, 10'h010, 32'h80AD_BEEF);
    do_store("SH hi", 3'b001, 10'h022, 32'h0000_1234, 4'b0011, 32'h1234_1234);
    do_load("LH hi", 3'b001, 10'h022, 32'h0000_1234);
    do_store("SH lo", 3'b001, 10'h020, 32'hFFFF_ABCD, 4'b1100, 32'hABCD_ABCD);
    do_load("LH lo", 3'b001, 10'h020, 32'hFFFF_ABCD);
    do_load("LHU lo", 3'b101, 10'h020, 32'h0000_ABCD);
    do_load("LW half word", 3'b010, 10'h020, 32'h1234_ABCD);

    do_error("LW misaligned", 1'b0, 3'b010, 10'h021, 32'h1234_ABCD);
    do_error("SB funct3=100", 1'b1, 3'b100, 10'h010, 32'h1234_ABCD);
    do_error("LH odd", 1'b0, 3'b001, 10'h023, 32'h1234_ABCD);
    do_error("funct3=011", 1'b0, 3'b011, 10'h010, 32'h1234_ABCD);
    do_load("err cleared", 3'b000, 10'h012, 32'hFFFF_FFAD);

    // Back-to-back with start held high
    is_store = 1'b1; funct3 = 3'b010; address = 10'h030; store_data = 32'h1122_3344; start = 1'b1;
    step();
    chk("b2b SW wen", {31'b0, ram_write_enable}, 32'd1);
    is_store = 1'b0;
    step();
    chk("b2b SW done", {30'b0, done, busy}, 32'd2);
    step();
    chk("b2b LW accepted", {30'b0, busy, done}, 32'd2);
    step();
    step();
    start = 1'b0;
    chk("b2b LW done", {31'b0, done}, 32'd1);
    chk("b2b LW data", load_data, 32'h1122_3344);
    step();
    chk("b2b idle", {30'b0, busy, done}, 32'd0);

    // Reset during READ
    issue(1'b0, 3'b010, 10'h010, 32'h0);
    chk("abort in READ", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    d0 = done_cnt;
    step();
    chk("abort state", {29'b0, busy, done, error}, 32'd0);
    chk("abort load_data", load_data, 32'd0);
    reset = 1'b1;
    repeat (4) step();
    chk("abort no done", done_cnt - d0, 32'd0);
    do_load("RAM intact 030", 3'b010, 10'h030, 32'h1122_3344);
    do_load("RAM intact 010", 3'b010, 10'h010, 32'h80AD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
